// File: rtl/gb_cfg_slave.sv
// GB-side responder to the CCU global-buffer configuration handshake.
// Checks bank allocation, publishes region bases and runs the layer loop counters.
module gb_cfg_slave #(
  parameter  int unsigned NUM_BANK   = 16,
  parameter  int unsigned BANK_IDX_W = 4,
  localparam int unsigned TOT_W      = 4,
  localparam int unsigned LOOP_WEI_W = 12,
  localparam int unsigned LOOP_ACT_W = 8,
  localparam int unsigned SUM_W      = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  CFGGB_val,
  input  logic [BANK_IDX_W-1:0] CFGGB_num_alloc_wei,
  input  logic [BANK_IDX_W-1:0] CFGGB_num_alloc_flgwei,
  input  logic [BANK_IDX_W-1:0] CFGGB_num_alloc_flgact,
  input  logic [BANK_IDX_W-1:0] CFGGB_num_alloc_act,
  input  logic [TOT_W-1:0]      CFGGB_num_total_flgwei,
  input  logic [TOT_W-1:0]      CFGGB_num_total_flgact,
  input  logic [TOT_W-1:0]      CFGGB_num_total_act,
  input  logic [LOOP_WEI_W-1:0] CFGGB_num_loop_wei,
  input  logic [LOOP_ACT_W-1:0] CFGGB_num_loop_act,
  input  logic                  CCUGB_pullback_wei,
  input  logic                  CCUGB_reset_all,
  input  logic                  wei_pass_done,
  input  logic                  act_pass_done,
  output logic                  GBCFG_rdy,
  output logic [BANK_IDX_W-1:0] base_wei,
  output logic [BANK_IDX_W-1:0] base_flgwei,
  output logic [BANK_IDX_W-1:0] base_flgact,
  output logic [BANK_IDX_W-1:0] base_act,
  output logic [TOT_W-1:0]      tot_flgwei,
  output logic [TOT_W-1:0]      tot_flgact,
  output logic [TOT_W-1:0]      tot_act,
  output logic [LOOP_WEI_W-1:0] cnt_loop_wei,
  output logic [LOOP_ACT_W-1:0] cnt_loop_act,
  output logic                  wei_rewind,
  output logic                  cfg_err,
  output logic                  layer_done,
  output logic                  busy
);

  typedef enum logic [2:0] {IDLE, CHECK, RUN, DONE, ERR} state_t;

  state_t st_q, st_d;

  logic [BANK_IDX_W-1:0] alloc_wei_q, alloc_flgwei_q, alloc_flgact_q, alloc_act_q;
  logic [LOOP_WEI_W-1:0] loop_wei_q;
  logic [LOOP_ACT_W-1:0] loop_act_q;

  logic             accept_c;
  logic [SUM_W-1:0] sum_c;
  logic             alloc_bad_c;
  logic             loops_done_c;

  assign accept_c = (st_q == IDLE) && CFGGB_val && GBCFG_rdy && !CCUGB_reset_all;
  assign sum_c    = SUM_W'(alloc_wei_q) + SUM_W'(alloc_flgwei_q)
                  + SUM_W'(alloc_flgact_q) + SUM_W'(alloc_act_q);
  assign alloc_bad_c = (alloc_wei_q == '0) || (alloc_flgwei_q == '0) ||
                       (alloc_flgact_q == '0) || (alloc_act_q == '0) ||
                       (sum_c > SUM_W'(NUM_BANK));
  // A zero loop count is complete from the start
  assign loops_done_c = (cnt_loop_wei >= loop_wei_q) && (cnt_loop_act >= loop_act_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st_q <= IDLE;
    else        st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    if (CCUGB_reset_all) begin
      st_d = IDLE;
    end else begin
      case (st_q)
        IDLE:    if (accept_c) st_d = CHECK;
        CHECK:   st_d = alloc_bad_c ? ERR : RUN;
        RUN:     if (loops_done_c) st_d = DONE;
        DONE:    st_d = IDLE;
        ERR:     st_d = ERR;
        default: st_d = IDLE;
      endcase
    end
  end

  // Config latch, bases, loop counters and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      GBCFG_rdy      <= 1'b1;
      busy           <= 1'b0;
      layer_done     <= 1'b0;
      wei_rewind     <= 1'b0;
      cfg_err        <= 1'b0;
      alloc_wei_q    <= '0;
      alloc_flgwei_q <= '0;
      alloc_flgact_q <= '0;
      alloc_act_q    <= '0;
      loop_wei_q     <= '0;
      loop_act_q     <= '0;
      tot_flgwei     <= '0;
      tot_flgact     <= '0;
      tot_act        <= '0;
      base_wei       <= '0;
      base_flgwei    <= '0;
      base_flgact    <= '0;
      base_act       <= '0;
      cnt_loop_wei   <= '0;
      cnt_loop_act   <= '0;
    end else begin
      GBCFG_rdy  <= (st_d == IDLE);
      busy       <= (st_d == CHECK) || (st_d == RUN);
      layer_done <= (st_d == DONE);
      wei_rewind <= !CCUGB_reset_all && (st_q == RUN) && CCUGB_pullback_wei;
      if (CCUGB_reset_all) begin
        cfg_err        <= 1'b0;
        alloc_wei_q    <= '0;
        alloc_flgwei_q <= '0;
        alloc_flgact_q <= '0;
        alloc_act_q    <= '0;
        loop_wei_q     <= '0;
        loop_act_q     <= '0;
        tot_flgwei     <= '0;
        tot_flgact     <= '0;
        tot_act        <= '0;
        base_wei       <= '0;
        base_flgwei    <= '0;
        base_flgact    <= '0;
        base_act       <= '0;
        cnt_loop_wei   <= '0;
        cnt_loop_act   <= '0;
      end else begin
        if (accept_c) begin
          alloc_wei_q    <= CFGGB_num_alloc_wei;
          alloc_flgwei_q <= CFGGB_num_alloc_flgwei;
          alloc_flgact_q <= CFGGB_num_alloc_flgact;
          alloc_act_q    <= CFGGB_num_alloc_act;
          loop_wei_q     <= CFGGB_num_loop_wei;
          loop_act_q     <= CFGGB_num_loop_act;
          tot_flgwei     <= CFGGB_num_total_flgwei;
          tot_flgact     <= CFGGB_num_total_flgact;
          tot_act        <= CFGGB_num_total_act;
          cnt_loop_wei   <= '0;
          cnt_loop_act   <= '0;
        end
        if (st_q == CHECK) begin
          if (alloc_bad_c) begin
            cfg_err <= 1'b1;
          end else begin
            // Partial sums stay within 15 when the total is legal
            base_wei    <= '0;
            base_flgwei <= alloc_wei_q;
            base_flgact <= BANK_IDX_W'(alloc_wei_q + alloc_flgwei_q);
            base_act    <= BANK_IDX_W'(alloc_wei_q + alloc_flgwei_q + alloc_flgact_q);
          end
        end
        if (st_q == RUN) begin
          if (wei_pass_done && (cnt_loop_wei < loop_wei_q))
            cnt_loop_wei <= cnt_loop_wei + LOOP_WEI_W'(1);
          if (act_pass_done && (cnt_loop_act < loop_act_q))
            cnt_loop_act <= cnt_loop_act + LOOP_ACT_W'(1);
        end
      end
    end
  end

endmodule

// File: doc/gb_cfg_slave.md
Name: gb_cfg_slave

Overview:
GB-side responder to the CCU's global-buffer configuration handshake (CFGGB_val / GBCFG_rdy).
- Accepts one layer configuration and checks the SRAM bank allocation.
- Publishes per-region bank base indices.
- Runs the weight and activation loop counters, which advance on pass-done pulses from the GB fetch engines.
- Signals layer completion back into the GB.
- Honours the CCU control strobes CCUGB_reset_all and CCUGB_pullback_wei.

Parameters:
NUM_BANK, 16, number of GB SRAM banks available for allocation.
BANK_IDX_W, 4, width of a bank index.

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
CFGGB_val  input  1  config valid, level
CFGGB_num_alloc_wei  input  4  banks for weights
CFGGB_num_alloc_flgwei  input  4  banks for weight flags
CFGGB_num_alloc_flgact  input  4  banks for activation flags
CFGGB_num_alloc_act  input  4  banks for activations
CFGGB_num_total_flgwei  input  4  total flgwei bank-fills per layer (latched, passed through)
CFGGB_num_total_flgact  input  4  total flgact bank-fills (latched, passed through)
CFGGB_num_total_act  input  4  total act bank-fills (latched, passed through)
CFGGB_num_loop_wei  input  12  weight passes per layer
CFGGB_num_loop_act  input  8  activation passes per layer
CCUGB_pullback_wei  input  1  registered strobe: rewind weight read pointer
CCUGB_reset_all  input  1  registered strobe: abort and clear
wei_pass_done  input  1  pulse from weight fetch engine
act_pass_done  input  1  pulse from activation fetch engine
GBCFG_rdy  output  1  ready for config, level
base_wei / base_flgwei / base_flgact / base_act  output  4 each  first bank index of each region
tot_flgwei / tot_flgact / tot_act  output  4 each  latched totals
cnt_loop_wei  output  12  completed weight passes
cnt_loop_act  output  8  completed activation passes
wei_rewind  output  1  one-cycle pulse
cfg_err  output  1  allocation error, sticky
layer_done  output  1  one-cycle pulse
busy  output  1  high in CHECK or RUN

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: state IDLE, GBCFG_rdy=1, all other outputs 0, config registers 0.
- States: IDLE, CHECK, RUN, DONE, ERR.
- Handshake: a transfer happens on a posedge where CFGGB_val && GBCFG_rdy.
  - GBCFG_rdy is a registered output, high only in IDLE.
  - It drops the cycle after acceptance.
  - CFGGB_val while rdy=0 is ignored; the fields are not sampled.
- On acceptance: latch all CFGGB_* fields and go to CHECK.
- CHECK (1 cycle):
  - sum = alloc_wei + alloc_flgwei + alloc_flgact + alloc_act, computed 6-bit, no truncation.
  - Error if any alloc==0 or sum > NUM_BANK → ERR, cfg_err=1.
  - Otherwise → RUN. Bases are registered at the CHECK→RUN transition:
    - base_wei=0
    - base_flgwei=alloc_wei
    - base_flgact=base_flgwei+alloc_flgwei
    - base_act=base_flgact+alloc_flgact
  - Base indices are 4 bits; when sum==16, base_act is at most 15, so no overflow.
- RUN:
  - wei_pass_done increments cnt_loop_wei, saturating at num_loop_wei.
  - act_pass_done increments cnt_loop_act, saturating at num_loop_act.
  - Simultaneous pulses increment both counters in the same cycle.
  - A loop count of 0 counts as already complete.
  - When both counters are complete (evaluated on the registered counter values) → DONE.
- DONE (1 cycle): layer_done=1; then → IDLE, rdy=1.
  - Counters and bases hold their values until the next acceptance.
  - Counters clear on acceptance.
- ERR: rdy=0 and cfg_err=1 until CCUGB_reset_all.
- CCUGB_pullback_wei:
  - In RUN: wei_rewind pulses exactly 1 cycle later; counters are unchanged.
  - In any other state: ignored.
- CCUGB_reset_all: highest priority, effective in any state next cycle.
  - State→IDLE; counters, bases, totals and cfg_err cleared; rdy=1 on the following cycle.
  - A coincident CFGGB_val is not accepted.
  - A coincident pass_done is dropped.
- pass_done pulses outside RUN are ignored.
- rst_n assertion mid-operation returns all outputs to their reset values immediately (async).

Test Plan:
- Alloc 4/2/2/8, loop_wei=3, loop_act=2 → rdy low 1 cycle after val; bases 0/4/6/8; after 3 wei + 2 act pulses, layer_done pulses once, then rdy=1.
- Alloc 8/4/4/4 (sum 20) → cfg_err=1 in 2 cycles, rdy stays 0; reset_all → cfg_err=0, rdy=1 next cycle.
- Alloc with alloc_flgact=0 → ERR; loop_wei=0, loop_act=1 → DONE after a single act pulse, wei pulses ignored.
- wei_pass_done and act_pass_done in the same cycle → both counters +1; extra wei pulses beyond num_loop_wei saturate at the limit.
- pullback_wei in RUN → wei_rewind one cycle later, counters unchanged; pullback in IDLE → no wei_rewind.
- reset_all coincident with val in IDLE → not accepted, rdy=1; rst_n pulsed mid-RUN → all outputs at reset values, rdy=1.
